// File: rtl/fir_seq_pkg.sv
// Shared types, widths and result arithmetic for the FIR stream sequencer.
package fir_seq_pkg;

    localparam int SAMPLE_WIDTH = 16;
    localparam int ACC_WIDTH    = 36;
    localparam int FRAC_SHIFT   = 15;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } seqState_t;

    typedef struct packed {
        logic                    clipped;
        logic [SAMPLE_WIDTH-1:0] value;
    } roundSat_t;

    localparam logic signed [ACC_WIDTH:0] ROUND_BIAS = (ACC_WIDTH+1)'(longint'(1) << (FRAC_SHIFT - 1));
    localparam logic signed [ACC_WIDTH:0] SAT_MAX    = (ACC_WIDTH+1)'((longint'(1) << (SAMPLE_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN    = ~SAT_MAX;

    // One guard bit above the accumulator keeps the rounding add from overflowing.
    function automatic roundSat_t round_sat(input logic signed [ACC_WIDTH-1:0] acc);
        logic signed [ACC_WIDTH:0] wide;
        logic signed [ACC_WIDTH:0] shifted;
        roundSat_t                 res;
        wide        = acc;
        wide        = wide + ROUND_BIAS;
        shifted     = wide >>> FRAC_SHIFT;
        res.clipped = 1'b0;
        res.value   = shifted[SAMPLE_WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            res.clipped = 1'b1;
            res.value   = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            res.clipped = 1'b1;
            res.value   = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
        end
        return res;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small register FIFO for input samples; head is always visible combinationally.
module sample_fifo
    import fir_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clkIn,
    input  logic                    nResetIn,
    input  logic                    push,
    input  logic [SAMPLE_WIDTH-1:0] pushData,
    input  logic                    pop,
    output logic [SAMPLE_WIDTH-1:0] head,
    output logic                    full,
    output logic                    empty
);

    localparam int PTR_W = $clog2(DEPTH);

    // Extra pointer MSB separates the full and empty cases when indices match.
    logic [PTR_W:0]          wrPtrReg;
    logic [PTR_W:0]          rdPtrReg;
    logic [SAMPLE_WIDTH-1:0] entryWord [DEPTH];
    logic                    doPush;
    logic                    doPop;

    assign full   = (wrPtrReg[PTR_W] != rdPtrReg[PTR_W]) &&
                    (wrPtrReg[PTR_W-1:0] == rdPtrReg[PTR_W-1:0]);
    assign empty  = (wrPtrReg == rdPtrReg);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign head   = entryWord[rdPtrReg[PTR_W-1:0]];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : gEntry
            logic [SAMPLE_WIDTH-1:0] entryReg;
            always_ff @(posedge clkIn or negedge nResetIn) begin
                if (!nResetIn) begin
                    entryReg <= '0;
                end else if (doPush && (wrPtrReg[PTR_W-1:0] == PTR_W'(gi))) begin
                    entryReg <= pushData;
                end
            end
            assign entryWord[gi] = entryReg;
        end
    endgenerate

    always_ff @(posedge clkIn or negedge nResetIn) begin
        if (!nResetIn) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
        end else begin
            if (doPush) wrPtrReg <= wrPtrReg + 1'b1;
            if (doPop)  rdPtrReg <= rdPtrReg + 1'b1;
        end
    end

endmodule

// File: rtl/fir_stream_sequencer.sv
// Feeds buffered samples to the FIR engine one at a time and returns
// rounded/saturated results on an output stream.
module fir_stream_sequencer
    import fir_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clkIn,
    input  logic                    nResetIn,
    input  logic [SAMPLE_WIDTH-1:0] sampleIn,
    input  logic                    sampleValidIn,
    output logic                    sampleReadyOut,
    output logic                    firStartOut,
    output logic [SAMPLE_WIDTH-1:0] firDataOut,
    input  logic                    firBusyIn,
    input  logic                    firDoneIn,
    input  logic [ACC_WIDTH-1:0]    firResultIn,
    output logic [SAMPLE_WIDTH-1:0] resultOut,
    output logic                    resultValidOut,
    input  logic                    resultReadyIn,
    output logic [7:0]              satCountOut,
    output logic                    protocolErrOut
);

    seqState_t               stateReg;
    seqState_t               stateNext;
    logic                    fifoFull;
    logic                    fifoEmpty;
    logic                    fifoPop;
    logic [SAMPLE_WIDTH-1:0] fifoHead;
    roundSat_t               rounded;
    logic [SAMPLE_WIDTH-1:0] resultReg;
    logic                    resultValidReg;
    logic [7:0]              satCountReg;
    logic                    protocolErrReg;
    logic                    captureResult;

    assign sampleReadyOut = !fifoFull;
    assign firDataOut     = fifoHead;
    assign resultOut      = resultReg;
    assign resultValidOut = resultValidReg;
    assign satCountOut    = satCountReg;
    assign protocolErrOut = protocolErrReg;

    sample_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) inputFifo (
        .clkIn   (clkIn),
        .nResetIn(nResetIn),
        .push    (sampleValidIn),
        .pushData(sampleIn),
        .pop     (fifoPop),
        .head    (fifoHead),
        .full    (fifoFull),
        .empty   (fifoEmpty)
    );

    always_ff @(posedge clkIn or negedge nResetIn) begin
        if (!nResetIn) stateReg <= IDLE;
        else           stateReg <= stateNext;
    end

    // A new operation waits for the output slot to drain so no result is lost.
    always_comb begin
        stateNext   = stateReg;
        firStartOut = 1'b0;
        fifoPop     = 1'b0;
        case (stateReg)
            IDLE: begin
                if (!fifoEmpty && !firBusyIn && !resultValidReg) stateNext = START;
            end
            START: begin
                firStartOut = 1'b1;
                fifoPop     = 1'b1;
                stateNext   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (firBusyIn) stateNext = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (firDoneIn) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign rounded       = round_sat($signed(firResultIn));
    assign captureResult = (stateReg == WAIT_DONE) && firDoneIn;

    always_ff @(posedge clkIn or negedge nResetIn) begin
        if (!nResetIn) begin
            resultReg      <= '0;
            resultValidReg <= 1'b0;
            satCountReg    <= '0;
            protocolErrReg <= 1'b0;
        end else begin
            if (captureResult) begin
                resultReg      <= rounded.value;
                resultValidReg <= 1'b1;
                if (rounded.clipped && (satCountReg != 8'hFF)) satCountReg <= satCountReg + 8'd1;
            end else if (resultValidReg && resultReadyIn) begin
                resultValidReg <= 1'b0;
            end
            if (firDoneIn && (stateReg != WAIT_DONE)) protocolErrReg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fir_stream_sequencer.sv
// Randomized bench for fir_stream_sequencer with a behavioural filter and result model.
module tb_fir_stream_sequencer;

    logic        clkIn = 1'b0;
    logic        nResetIn = 1'b0;
    logic [15:0] sampleIn = '0;
    logic        sampleValidIn = 1'b0;
    logic        sampleReadyOut;
    logic        firStartOut;
    logic [15:0] firDataOut;
    logic        firBusyIn = 1'b0;
    logic        firDoneIn = 1'b0;
    logic [35:0] firResultIn = '0;
    logic [15:0] resultOut;
    logic        resultValidOut;
    logic        resultReadyIn = 1'b0;
    logic [7:0]  satCountOut;
    logic        protocolErrOut;

    fir_stream_sequencer dut (
        .clkIn         (clkIn),
        .nResetIn      (nResetIn),
        .sampleIn      (sampleIn),
        .sampleValidIn (sampleValidIn),
        .sampleReadyOut(sampleReadyOut),
        .firStartOut   (firStartOut),
        .firDataOut    (firDataOut),
        .firBusyIn     (firBusyIn),
        .firDoneIn     (firDoneIn),
        .firResultIn   (firResultIn),
        .resultOut     (resultOut),
        .resultValidOut(resultValidOut),
        .resultReadyIn (resultReadyIn),
        .satCountOut   (satCountOut),
        .protocolErrOut(protocolErrOut)
    );

    always #5 clkIn = ~clkIn;

    int          checkCount = 0;
    int          errorCount = 0;
    int          cycleCount = 0;
    int          startCount = 0;
    int          lastStartCycle = -1;
    int          satExp = 0;
    int          fltCnt = 0;
    bit          fltActive = 0;
    bit          modelDone = 0;
    bit          prevStart = 0;
    bit          randReady = 0;
    longint      fltAcc = 0;
    logic [15:0] lastResult = '0;
    logic [15:0] pushQ [$];
    logic [15:0] expQ [$];
    longint      accQ [$];

    task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycleCount);
        end
    endtask

    // Round half up then clamp, done with plain integer division.
    function automatic logic [15:0] refRound(input longint acc, output bit clip);
        longint biased;
        longint q;
        biased = acc + 16384;
        if (biased >= 0) q = biased / 32768;
        else             q = -((-biased + 32767) / 32768);
        clip = 1'b0;
        if (q > 32767) begin
            q    = 32767;
            clip = 1'b1;
        end else if (q < -32768) begin
            q    = -32768;
            clip = 1'b1;
        end
        return q[15:0];
    endfunction

    function automatic longint randomAcc();
        logic [35:0] raw;
        longint      v;
        case ($urandom_range(0, 4))
            0: begin
                raw = {4'($urandom), 32'($urandom)};
                v   = longint'($signed(raw));
            end
            1: v = longint'($signed(16'($urandom))) * 32768 - 16384;
            2: v = longint'($signed(16'($urandom))) * 32768 - 16385;
            default: v = longint'($signed(32'($urandom))) >>> $urandom_range(0, 16);
        endcase
        return v;
    endfunction

    // One clock: capture pre-edge handshakes, step the filter model at the falling edge.
    task automatic tick();
        logic        pushed;
        logic        taken;
        logic        doneDriven;
        logic [15:0] inSample;
        logic [15:0] outSample;
        logic [15:0] expResult;
        bit          clip;
        pushed     = sampleValidIn && sampleReadyOut;
        inSample   = sampleIn;
        taken      = resultValidOut && resultReadyIn;
        outSample  = resultOut;
        doneDriven = modelDone;
        @(posedge clkIn);
        @(negedge clkIn);
        cycleCount++;
        if (pushed) pushQ.push_back(inSample);
        if (taken) begin
            $display("result accepted: 0x%04h at cycle %0d", outSample, cycleCount);
            if (expQ.size() == 0) checkValue("unexpectedResult", 1, 0);
            else                  checkValue("result", outSample, expQ.pop_front());
            lastResult = outSample;
        end
        if (doneDriven) checkValue("doneToValid", resultValidOut, 1);

        firDoneIn   = 1'b0;
        modelDone   = 1'b0;
        firResultIn = {4'($urandom), 32'($urandom)};
        if (firStartOut) begin
            checkValue("startWidth", prevStart, 0);
            checkValue("startGate", {fltActive, expQ.size() != 0}, 0);
            if (pushQ.size() == 0) checkValue("startNoSample", 1, 0);
            else                   checkValue("startData", firDataOut, pushQ.pop_front());
            startCount++;
            lastStartCycle = cycleCount;
            fltActive = 1;
            firBusyIn = 1'b1;
            fltCnt    = $urandom_range(2, 4);
            fltAcc    = (accQ.size() > 0) ? accQ.pop_front() : randomAcc();
        end else if (fltActive) begin
            if (fltCnt == 0) begin
                firDoneIn   = 1'b1;
                modelDone   = 1'b1;
                firBusyIn   = 1'b0;
                fltActive   = 0;
                firResultIn = fltAcc[35:0];
                expResult   = refRound(fltAcc, clip);
                expQ.push_back(expResult);
                if (clip && satExp < 255) satExp++;
            end else begin
                fltCnt--;
            end
        end
        prevStart = firStartOut;
        if (randReady) resultReadyIn = ($urandom_range(0, 2) != 0);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        sampleValidIn = 1'b0;
        resultReadyIn = 1'b1;
        while ((pushQ.size() != 0 || fltActive || expQ.size() != 0 || resultValidOut) && n < budget) begin
            tick();
            n++;
        end
        checkValue("drainTimeout", n < budget, 1);
    endtask

    initial begin
        int base;
        int pushCycle;

        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            @(negedge clkIn);
            sampleIn      = 16'($urandom);
            sampleValidIn = 1'($urandom);
            firBusyIn     = 1'($urandom);
            firDoneIn     = 1'($urandom);
            firResultIn   = {4'($urandom), 32'($urandom)};
            resultReadyIn = 1'($urandom);
        end
        @(negedge clkIn);
        checkValue("rstStart", firStartOut, 0);
        checkValue("rstData", firDataOut, 0);
        checkValue("rstResult", resultOut, 0);
        checkValue("rstValid", resultValidOut, 0);
        checkValue("rstSat", satCountOut, 0);
        checkValue("rstProto", protocolErrOut, 0);
        checkValue("rstReady", sampleReadyOut, 1);
        sampleValidIn = 1'b0;
        firBusyIn     = 1'b0;
        firDoneIn     = 1'b0;
        resultReadyIn = 1'b0;
        nResetIn      = 1'b1;
        @(negedge clkIn);
        checkValue("relReady", sampleReadyOut, 1);
        checkValue("relProto", protocolErrOut, 0);

        // Single sample with a known accumulator
        resultReadyIn = 1'b1;
        accQ.push_back(64'h4000);
        sampleIn      = 16'h1234;
        sampleValidIn = 1'b1;
        tick();
        pushCycle     = cycleCount;
        sampleValidIn = 1'b0;
        tick();
        checkValue("startLatency", lastStartCycle, pushCycle + 1);
        drain(40);
        checkValue("singleResult", lastResult, 16'h0001);
        checkValue("singleStarts", startCount, 1);

        // Saturation at both rails
        accQ.push_back(64'sh7_FFFF_FFFF);
        accQ.push_back(-64'sh8_0000_0000);
        for (int i = 0; i < 2; i++) begin
            sampleIn      = 16'($urandom);
            sampleValidIn = 1'b1;
            tick();
        end
        drain(80);
        checkValue("satNegResult", lastResult, 16'h8000);
        checkValue("satCount", satCountOut, 2);

        // Backpressure: output stalled, FIFO fills
        resultReadyIn = 1'b0;
        base = startCount;
        for (int i = 0; i < 6; i++) begin
            sampleIn      = 16'($urandom);
            sampleValidIn = 1'b1;
            tick();
        end
        sampleValidIn = 1'b0;
        repeat (12) tick();
        checkValue("bpStarts", startCount - base, 1);
        checkValue("bpReady", sampleReadyOut, 0);
        checkValue("bpQueued", pushQ.size(), 4);
        checkValue("bpValid", resultValidOut, 1);
        drain(200);
        checkValue("bpAllStarts", startCount - base, 5);

        // Stray done while idle
        checkValue("protoClean", protocolErrOut, 0);
        firDoneIn = 1'b1;
        tick();
        checkValue("strayErr", protocolErrOut, 1);
        checkValue("strayValid", resultValidOut, 0);

        // Reset while waiting for done
        resultReadyIn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sampleIn      = 16'($urandom);
            sampleValidIn = 1'b1;
            tick();
        end
        sampleValidIn = 1'b0;
        tick();
        nResetIn = 1'b0;
        #1;
        checkValue("midRstValid", resultValidOut, 0);
        checkValue("midRstStart", firStartOut, 0);
        checkValue("midRstReady", sampleReadyOut, 1);
        checkValue("midRstProto", protocolErrOut, 0);
        checkValue("midRstSat", satCountOut, 0);
        checkValue("midRstData", firDataOut, 0);
        pushQ.delete();
        expQ.delete();
        accQ.delete();
        fltActive = 0;
        modelDone = 0;
        prevStart = 0;
        satExp    = 0;
        firBusyIn = 1'b0;
        firDoneIn = 1'b0;
        @(negedge clkIn);
        nResetIn = 1'b1;
        base = startCount;
        repeat (10) tick();
        checkValue("midRstNoStart", startCount - base, 0);
        checkValue("midRstNoResult", resultValidOut, 0);

        // Random traffic with random output backpressure
        randReady = 1;
        for (int i = 0; i < 400; i++) begin
            sampleValidIn = 1'($urandom_range(0, 1));
            sampleIn      = 16'($urandom);
            tick();
        end
        randReady = 0;
        drain(300);
        checkValue("finalSat", satCountOut, satExp);
        checkValue("finalReady", sampleReadyOut, 1);
        checkValue("finalProto", protocolErrOut, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
